// File: rtl/memory_stage_if.sv
// Data-memory port between the memory stage and the data memory.
// The stage drives a request with address, write enable and write data and
// holds them until the memory answers with ack (and read data on loads).
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, address/status resolution and a
// two-state handshake with a variable-latency data memory. While an access
// is outstanding m_busy stays high and the M register holds its contents.
module memory_stage (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           E_stat,
  input  logic [3:0]           E_Ins_Code,
  input  logic                 e_Cnd,
  input  logic [63:0]          e_Value_E,
  input  logic [63:0]          E_valA,
  input  logic [3:0]           e_dstE,
  input  logic [3:0]           E_dstM,
  input  logic                 M_stall,
  input  logic                 M_bubble,
  output logic [3:0]           M_Ins_Code,
  output logic [63:0]          m_Value_E,
  output logic [63:0]          m_valM,
  output logic [3:0]           m_dstE,
  output logic [3:0]           m_dstM,
  output logic [2:0]           m_stat,
  output logic                 m_busy,
  memory_stage_if.master       dmem
);

  localparam logic [2:0]  STAT_AOK   = 3'd0;
  localparam logic [2:0]  STAT_ADR   = 3'd2;
  localparam logic [3:0]  REG_NONE   = 4'hF;
  localparam logic [3:0]  ICODE_NOP  = 4'h1;
  localparam logic [63:0] DMEM_LIMIT = 64'h1000;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  // rmmovq, call, pushq store to memory
  function automatic logic is_write(input logic [3:0] code);
    return (code == 4'd4) || (code == 4'd8) || (code == 4'd10);
  endfunction

  // mrmovq, ret, popq load from memory
  function automatic logic is_read(input logic [3:0] code);
    return (code == 4'd5) || (code == 4'd9) || (code == 4'd11);
  endfunction

  // ret and popq address through the old stack pointer carried in valA
  function automatic logic [63:0] mem_addr(input logic [3:0]  code,
                                           input logic [63:0] val_e,
                                           input logic [63:0] val_a);
    return ((code == 4'd9) || (code == 4'd11)) ? val_a : val_e;
  endfunction

  // ---- stage p0: decode the incoming execute results ----
  logic        load_p0;
  logic        rd_p0;
  logic        wr_p0;
  logic        acc_p0;
  logic [63:0] addr_p0;
  logic        in_range_p0;
  logic        stat_ok_p0;
  logic        start_p0;
  logic        adr_fault_p0;
  logic        ack_p0;

  assign load_p0      = !M_stall && (state_q == IDLE);
  assign rd_p0        = is_read(E_Ins_Code);
  assign wr_p0        = is_write(E_Ins_Code);
  assign acc_p0       = rd_p0 || wr_p0;
  assign addr_p0      = mem_addr(E_Ins_Code, e_Value_E, E_valA);
  assign in_range_p0  = addr_p0 < DMEM_LIMIT;
  assign stat_ok_p0   = (E_stat == STAT_AOK);
  assign start_p0     = load_p0 && !M_bubble && stat_ok_p0 && acc_p0 && in_range_p0;
  assign adr_fault_p0 = stat_ok_p0 && acc_p0 && !in_range_p0;
  assign ack_p0       = (state_q == ACCESS) && dmem.dmem_ack;

  // ---- stage p1: M register ----
  logic [2:0]  m_stat_p1;
  logic [3:0]  m_icode_p1;
  logic        m_cnd_p1;
  logic [63:0] m_val_e_p1;
  logic [63:0] m_val_m_p1;
  logic [3:0]  m_dst_e_p1;
  logic [3:0]  m_dst_m_p1;
  logic        m_rd_p1;
  logic        unused_cnd;

  // State register of the memory handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start on a valid in-range access, finish on the sampled ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_p0) state_d = ACCESS;
      ACCESS:  if (dmem.dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // M register: load, bubble to nop, hold while stalled/busy, capture load data on ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stat_p1  <= STAT_AOK;
      m_icode_p1 <= ICODE_NOP;
      m_cnd_p1   <= 1'b0;
      m_val_e_p1 <= '0;
      m_val_m_p1 <= '0;
      m_dst_e_p1 <= REG_NONE;
      m_dst_m_p1 <= REG_NONE;
      m_rd_p1    <= 1'b0;
    end else if (load_p0) begin
      m_val_m_p1 <= '0;
      if (M_bubble) begin
        m_stat_p1  <= STAT_AOK;
        m_icode_p1 <= ICODE_NOP;
        m_cnd_p1   <= 1'b0;
        m_val_e_p1 <= '0;
        m_dst_e_p1 <= REG_NONE;
        m_dst_m_p1 <= REG_NONE;
        m_rd_p1    <= 1'b0;
      end else begin
        // upstream faults win; an out-of-range access becomes ADR with no load target
        m_stat_p1  <= stat_ok_p0 ? (adr_fault_p0 ? STAT_ADR : STAT_AOK) : E_stat;
        m_icode_p1 <= E_Ins_Code;
        m_cnd_p1   <= e_Cnd;
        m_val_e_p1 <= e_Value_E;
        m_dst_e_p1 <= e_dstE;
        m_dst_m_p1 <= adr_fault_p0 ? REG_NONE : E_dstM;
        m_rd_p1    <= rd_p0;
      end
    end else if (ack_p0 && m_rd_p1) begin
      m_val_m_p1 <= dmem.dmem_rdata;
    end
  end

  // Request fields are captured once at the start and held until the ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
    end else if (start_p0) begin
      dmem.dmem_we    <= wr_p0;
      dmem.dmem_addr  <= addr_p0;
      dmem.dmem_wdata <= E_valA;
    end else if (ack_p0) begin
      dmem.dmem_we    <= 1'b0;
    end
  end

  assign dmem.dmem_req = (state_q == ACCESS);
  assign m_busy        = (state_q == ACCESS);

  assign M_Ins_Code = m_icode_p1;
  assign m_Value_E  = m_val_e_p1;
  assign m_valM     = m_val_m_p1;
  assign m_dstE     = m_dst_e_p1;
  assign m_dstM     = m_dst_m_p1;
  assign m_stat     = m_stat_p1;

  // the branch condition only rides along with the instruction
  assign unused_cnd = m_cnd_p1;

endmodule
